uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, BIT_PERIOD clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  localparam logic [7:0] LAST_CNT = 8'(BIT_PERIOD - 1);
  localparam logic [7:0] DONE_CNT = 8'(BIT_PERIOD - 2);

  state_t     state;
  logic [7:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic       par_bit;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_cnt    <= 8'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt    <= 8'd0;
          bit_idx    <= 3'd0;
          serial_out <= 1'b1;
          busy       <= 1'b0;
          if (tx_start) begin
            shreg      <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_bit    <= ^tx_data;
`endif
            serial_out <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_cnt == LAST_CNT) begin
            bit_cnt    <= 8'd0;
            serial_out <= shreg[0];
            state      <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_cnt == LAST_CNT) begin
            bit_cnt <= 8'd0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              serial_out <= par_bit;
              state      <= PARITY;
`else
              serial_out <= 1'b1;
              state      <= STOP;
`endif
            end else begin
              // shreg[0] is the bit on the line; shreg[1] is the next one
              bit_idx    <= bit_idx + 3'd1;
              shreg      <= {1'b0, shreg[7:1]};
              serial_out <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_cnt == LAST_CNT) begin
            bit_cnt    <= 8'd0;
            serial_out <= 1'b1;
            state      <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
`endif
        STOP: begin
          if (bit_cnt == LAST_CNT) begin
            bit_cnt    <= 8'd0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
            // registered, so raise it one edge early to land on the final stop cycle
            if (bit_cnt == DONE_CNT) tx_done <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          bit_cnt    <= 8'd0;
          bit_idx    <= 3'd0;
          serial_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: BIT_PERIOD=10 instance plus a BIT_PERIOD=2 instance.
module tb_uart_tx;

  localparam int BP  = 10;
  localparam int BP2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;

  logic       clk;
  logic       n_rst;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic       serial_out, serial_out2;
  logic       busy, busy2;
  logic       tx_done, tx_done2;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(.BIT_PERIOD(BP)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
    .serial_out(serial_out), .busy(busy), .tx_done(tx_done)
  );

  uart_tx #(.BIT_PERIOD(BP2)) dut2 (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start2), .tx_data(tx_data2),
    .serial_out(serial_out2), .busy(busy2), .tx_done(tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bit idx of the frame: 0 start, 1..8 data LSB first, parity, stop
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic accept(input logic [7:0] d, input bit hold);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    check("accept_so", serial_out, 1'b0);
    check("accept_busy", busy, 1'b1);
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic frame_body(input logic [7:0] d, input int pulse_at, input logic [7:0] pd);
    for (int k = 1; k <= NB*BP; k++) begin
      check($sformatf("so_%02h_c%0d", d, k), serial_out, exp_bit(d, (k-1)/BP));
      check($sformatf("busy_%02h_c%0d", d, k), busy, 1'b1);
      check($sformatf("done_%02h_c%0d", d, k), tx_done, (k == NB*BP));
      if (pulse_at > 0 && k == pulse_at) begin
        tx_start = 1'b1;
        tx_data  = pd;
      end else if (pulse_at > 0 && k == pulse_at + 1) begin
        tx_start = 1'b0;
      end
      tick();
    end
    check("end_busy", busy, 1'b0);
    check("end_so", serial_out, 1'b1);
    check("end_done", tx_done, 1'b0);
  endtask

  int a5_seq [11];

  initial begin
    n_rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    tx_start2 = 1'b0; tx_data2 = 8'h00;
    repeat (3) tick();
    check("rst_so", serial_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_so2", serial_out2, 1'b1);
    n_rst = 1'b1;
    repeat (2) tick();
    check("idle_so", serial_out, 1'b1);

    // A5 frame against a hand-written line sequence
`ifdef UART_TX_PARITY_EN
    a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    accept(8'hA5, 1'b0);
    for (int k = 1; k <= NB*BP; k++) begin
      check($sformatf("a5_so_c%0d", k), serial_out, a5_seq[(k-1)/BP]);
      check($sformatf("a5_done_c%0d", k), tx_done, (k == NB*BP));
      tick();
    end
    check("a5_busy_after", busy, 1'b0);
    check("a5_done_after", tx_done, 1'b0);
    repeat (3) tick();

    // request mid-frame with different data is ignored
    accept(8'hA5, 1'b0);
    frame_body(8'hA5, 30, 8'h00);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("no_second_busy_%0d", k), busy, 1'b0);
      check($sformatf("no_second_so_%0d", k), serial_out, 1'b1);
    end

    // held request: back-to-back frames with a single idle cycle
    accept(8'h3C, 1'b1);
    frame_body(8'h3C, 0, 8'h00);
    tick();
    check("b2b_start_so", serial_out, 1'b0);
    check("b2b_start_busy", busy, 1'b1);
    tx_start = 1'b0;
    frame_body(8'h3C, 0, 8'h00);
    repeat (2) tick();

    // async reset during data bit 3
    accept(8'hA5, 1'b0);
    repeat (44) tick();
    check("pre_rst_so", serial_out, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_so", serial_out, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    #2 n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("post_rst_so_%0d", k), serial_out, 1'b1);
      check($sformatf("post_rst_busy_%0d", k), busy, 1'b0);
    end
    accept(8'hC3, 1'b0);
    frame_body(8'hC3, 0, 8'h00);
    repeat (2) tick();

`ifdef UART_TX_PARITY_EN
    accept(8'h07, 1'b0);
    repeat (94) tick();
    check("par07_bit", serial_out, 1'b1);
    repeat (15) tick();
    check("par07_done", tx_done, 1'b1);
    tick();
    check("par07_busy", busy, 1'b0);
    repeat (2) tick();
    accept(8'h03, 1'b0);
    repeat (94) tick();
    check("par03_bit", serial_out, 1'b0);
    repeat (15) tick();
    check("par03_done", tx_done, 1'b1);
    tick();
    check("par03_busy", busy, 1'b0);
    repeat (2) tick();
`endif

    // minimum bit period
    tx_data2  = 8'hFF;
    tx_start2 = 1'b1;
    tick();
    check("bp2_accept_so", serial_out2, 1'b0);
    check("bp2_accept_busy", busy2, 1'b1);
    tx_start2 = 1'b0;
    for (int k = 1; k <= NB*BP2; k++) begin
      check($sformatf("bp2_so_c%0d", k), serial_out2, exp_bit(8'hFF, (k-1)/BP2));
      check($sformatf("bp2_done_c%0d", k), tx_done2, (k == NB*BP2));
      tick();
    end
    check("bp2_busy_after", busy2, 1'b0);
    check("bp2_so_after", serial_out2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
